// File: rtl/int_pc_ctrl.sv
// Next-PC selection with a nested, prioritised interrupt controller.
// Interrupt entry pushes the would-be next PC; irq_done pops it back.
module int_pc_ctrl #(
    parameter int          NUM_IRQ    = 3,
    parameter logic [31:0] VEC_BASE   = 32'h38,
    parameter logic [31:0] VEC_STRIDE = 32'h38,
    localparam int         DW         = $clog2(NUM_IRQ + 1)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               enable,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               irq_done,
    input  logic [31:0]        PC_old,
    input  logic [31:0]        ext_18,
    input  logic [25:0]        jmp_dest,
    input  logic               branch,
    input  logic               jmp,
    input  logic               Jr,
    input  logic [31:0]        RS,
    output logic [31:0]        PC_next,
    output logic [31:0]        sequencial_addr,
    output logic [NUM_IRQ-1:0] irq_active,
    output logic [DW-1:0]      irq_depth,
    output logic               irq_err
);

    logic [31:0]        branch_addr;
    logic [31:0]        jmp_addr;
    logic [31:0]        normal_next;
    logic [31:0]        vector;
    logic [DW-1:0]      cur_lvl;
    logic [DW-1:0]      sel;
    logic [NUM_IRQ-1:0] top_oh;
    logic [NUM_IRQ-1:0] take_oh;
    logic               take;
    logic [31:0]        stack [NUM_IRQ];

    assign sequencial_addr = PC_old + 32'd4;
    assign branch_addr     = sequencial_addr + ext_18;
    assign jmp_addr        = {PC_old[31:28], jmp_dest, 2'b00};
    assign vector          = VEC_BASE + VEC_STRIDE * 32'(sel);

    always_comb begin
        normal_next = sequencial_addr;
        if (jmp && Jr)
            normal_next = RS;
        else if (jmp)
            normal_next = jmp_addr;
        else if (branch)
            normal_next = branch_addr;
    end

    // Ascending scans: the last hit is the highest-priority one.
    always_comb begin
        cur_lvl = '0;
        top_oh  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_active[i]) begin
                cur_lvl   = DW'(i + 1);
                top_oh    = '0;
                top_oh[i] = 1'b1;
            end
        end
        take    = 1'b0;
        take_oh = '0;
        sel     = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (irq_req[i] && !irq_mask[i] && !irq_active[i] && (DW'(i + 1) > cur_lvl)) begin
                take       = 1'b1;
                take_oh    = '0;
                take_oh[i] = 1'b1;
                sel        = DW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            PC_next    <= '0;
            irq_active <= '0;
            irq_depth  <= '0;
            irq_err    <= 1'b0;
        end else if (enable) begin
            if (irq_done) begin
                if (irq_depth != '0) begin
                    PC_next    <= stack[irq_depth - DW'(1)];
                    irq_active <= irq_active & ~top_oh;
                    irq_depth  <= irq_depth - DW'(1);
                end else begin
                    PC_next <= normal_next;
                    irq_err <= 1'b1;
                end
            end else if (take) begin
                PC_next    <= vector;
                irq_active <= irq_active | take_oh;
                irq_depth  <= irq_depth + DW'(1);
            end else begin
                PC_next <= normal_next;
            end
        end
    end

    // A take implies depth < NUM_IRQ, so the push index is always in range.
    always_ff @(posedge clk) begin
        if (!clr && enable && !irq_done && take)
            stack[irq_depth] <= normal_next;
    end

endmodule

// File: tb/tb_int_pc_ctrl.sv
// Directed bench for int_pc_ctrl: next-PC muxing, interrupt nesting,
// priority, error, enable hold and clear.
module tb_int_pc_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        enable;
    logic [2:0]  irq_req;
    logic [2:0]  irq_mask;
    logic        irq_done;
    logic [31:0] PC_old;
    logic [31:0] ext_18;
    logic [25:0] jmp_dest;
    logic        branch;
    logic        jmp;
    logic        Jr;
    logic [31:0] RS;
    logic [31:0] PC_next;
    logic [31:0] sequencial_addr;
    logic [2:0]  irq_active;
    logic [1:0]  irq_depth;
    logic        irq_err;

    int checks   = 0;
    int failures = 0;

    int_pc_ctrl #(.NUM_IRQ(3), .VEC_BASE(32'h38), .VEC_STRIDE(32'h38)) dut (
        .clk(clk), .clr(clr), .enable(enable), .irq_req(irq_req), .irq_mask(irq_mask),
        .irq_done(irq_done), .PC_old(PC_old), .ext_18(ext_18), .jmp_dest(jmp_dest),
        .branch(branch), .jmp(jmp), .Jr(Jr), .RS(RS), .PC_next(PC_next),
        .sequencial_addr(sequencial_addr), .irq_active(irq_active),
        .irq_depth(irq_depth), .irq_err(irq_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; enable = 1'b0; irq_req = '0; irq_mask = '0; irq_done = 1'b0;
        PC_old = 32'h0; ext_18 = 32'h0; jmp_dest = '0; branch = 1'b0; jmp = 1'b0;
        Jr = 1'b0; RS = 32'h0;
        step(); step();
        checks++; if (PC_next !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", PC_next, 32'h0); end
        checks++; if (irq_active !== 3'b000) begin failures++; $display("FAIL reset_active got=%b exp=000", irq_active); end
        checks++; if (irq_depth !== 2'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", irq_depth); end
        checks++; if (irq_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", irq_err); end
        clr = 1'b0; enable = 1'b1;
    endtask

    task automatic test_normal();
        PC_old = 32'h100;
        #1;
        checks++; if (sequencial_addr !== 32'h104) begin failures++; $display("FAIL seq_addr got=%h exp=%h", sequencial_addr, 32'h104); end
        step();
        checks++; if (PC_next !== 32'h104) begin failures++; $display("FAIL normal_seq got=%h exp=%h", PC_next, 32'h104); end
        jmp = 1'b1; Jr = 1'b1; RS = 32'h400;
        step();
        checks++; if (PC_next !== 32'h400) begin failures++; $display("FAIL normal_jr got=%h exp=%h", PC_next, 32'h400); end
        Jr = 1'b0; PC_old = 32'hA000_0100; jmp_dest = 26'h123;
        step();
        checks++; if (PC_next !== 32'hA000_048C) begin failures++; $display("FAIL normal_jmp got=%h exp=%h", PC_next, 32'hA000_048C); end
        jmp = 1'b0; branch = 1'b1; PC_old = 32'h100; ext_18 = 32'h20;
        step();
        checks++; if (PC_next !== 32'h124) begin failures++; $display("FAIL branch_fwd got=%h exp=%h", PC_next, 32'h124); end
        ext_18 = 32'hFFFF_FFF8;
        step();
        checks++; if (PC_next !== 32'hFC) begin failures++; $display("FAIL branch_back got=%h exp=%h", PC_next, 32'hFC); end
        branch = 1'b0; ext_18 = 32'h0; PC_old = 32'hFFFF_FFFC;
        step();
        checks++; if (PC_next !== 32'h0) begin failures++; $display("FAIL seq_wrap got=%h exp=%h", PC_next, 32'h0); end
    endtask

    task automatic test_single_irq();
        PC_old = 32'h200; irq_req = 3'b001;
        step();
        checks++; if (PC_next !== 32'h38) begin failures++; $display("FAIL irq0_vec got=%h exp=%h", PC_next, 32'h38); end
        checks++; if (irq_depth !== 2'd1) begin failures++; $display("FAIL irq0_depth got=%0d exp=1", irq_depth); end
        checks++; if (irq_active !== 3'b001) begin failures++; $display("FAIL irq0_active got=%b exp=001", irq_active); end
        irq_req = 3'b000; PC_old = 32'h38;
        step();
        checks++; if (PC_next !== 32'h3C) begin failures++; $display("FAIL irq0_handler got=%h exp=%h", PC_next, 32'h3C); end
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        checks++; if (PC_next !== 32'h204) begin failures++; $display("FAIL irq0_ret got=%h exp=%h", PC_next, 32'h204); end
        checks++; if (irq_active !== 3'b000) begin failures++; $display("FAIL irq0_ret_active got=%b exp=000", irq_active); end
        checks++; if (irq_depth !== 2'd0) begin failures++; $display("FAIL irq0_ret_depth got=%0d exp=0", irq_depth); end
    endtask

    task automatic test_nesting();
        PC_old = 32'h300; irq_req = 3'b001;
        step();
        irq_req = 3'b100; PC_old = 32'h40;
        step();
        checks++; if (PC_next !== 32'hA8) begin failures++; $display("FAIL nest_vec got=%h exp=%h", PC_next, 32'hA8); end
        checks++; if (irq_depth !== 2'd2) begin failures++; $display("FAIL nest_depth got=%0d exp=2", irq_depth); end
        checks++; if (irq_active !== 3'b101) begin failures++; $display("FAIL nest_active got=%b exp=101", irq_active); end
        irq_req = 3'b000; irq_done = 1'b1; PC_old = 32'hAC;
        step();
        checks++; if (PC_next !== 32'h44) begin failures++; $display("FAIL nest_ret1 got=%h exp=%h", PC_next, 32'h44); end
        checks++; if (irq_active !== 3'b001) begin failures++; $display("FAIL nest_ret1_active got=%b exp=001", irq_active); end
        step();
        irq_done = 1'b0;
        checks++; if (PC_next !== 32'h304) begin failures++; $display("FAIL nest_ret2 got=%h exp=%h", PC_next, 32'h304); end
        checks++; if (irq_depth !== 2'd0) begin failures++; $display("FAIL nest_ret2_depth got=%0d exp=0", irq_depth); end
    endtask

    task automatic test_priority();
        PC_old = 32'h500; irq_req = 3'b100;
        step();
        checks++; if (PC_next !== 32'hA8) begin failures++; $display("FAIL prio_hi got=%h exp=%h", PC_next, 32'hA8); end
        irq_req = 3'b111; PC_old = 32'hA8;
        step();
        checks++; if (PC_next !== 32'hAC) begin failures++; $display("FAIL prio_blocked got=%h exp=%h", PC_next, 32'hAC); end
        checks++; if (irq_active !== 3'b100) begin failures++; $display("FAIL prio_blocked_active got=%b exp=100", irq_active); end
        irq_req = 3'b010; irq_done = 1'b1;
        step();
        checks++; if (PC_next !== 32'h504) begin failures++; $display("FAIL prio_ret got=%h exp=%h", PC_next, 32'h504); end
        checks++; if (irq_active !== 3'b000) begin failures++; $display("FAIL prio_ret_active got=%b exp=000", irq_active); end
        irq_done = 1'b0; PC_old = 32'h504;
        step();
        checks++; if (PC_next !== 32'h70) begin failures++; $display("FAIL prio_lo_vec got=%h exp=%h", PC_next, 32'h70); end
        checks++; if (irq_active !== 3'b010) begin failures++; $display("FAIL prio_lo_active got=%b exp=010", irq_active); end
        irq_req = 3'b000; irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        checks++; if (PC_next !== 32'h508) begin failures++; $display("FAIL prio_lo_ret got=%h exp=%h", PC_next, 32'h508); end
        checks++; if (irq_depth !== 2'd0) begin failures++; $display("FAIL prio_lo_ret_depth got=%0d exp=0", irq_depth); end
    endtask

    task automatic test_error_mask();
        PC_old = 32'h600; irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        checks++; if (irq_err !== 1'b1) begin failures++; $display("FAIL underflow_err got=%b exp=1", irq_err); end
        checks++; if (PC_next !== 32'h604) begin failures++; $display("FAIL underflow_pc got=%h exp=%h", PC_next, 32'h604); end
        checks++; if (irq_depth !== 2'd0) begin failures++; $display("FAIL underflow_depth got=%0d exp=0", irq_depth); end
        PC_old = 32'h700; irq_mask = 3'b111; irq_req = 3'b111;
        step();
        checks++; if (PC_next !== 32'h704) begin failures++; $display("FAIL masked_pc got=%h exp=%h", PC_next, 32'h704); end
        checks++; if (irq_depth !== 2'd0) begin failures++; $display("FAIL masked_depth got=%0d exp=0", irq_depth); end
        checks++; if (irq_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", irq_err); end
        irq_mask = 3'b000; irq_req = 3'b001;
        step();
        irq_mask = 3'b001; irq_req = 3'b000; irq_done = 1'b1;
        step();
        irq_done = 1'b0; irq_mask = 3'b000;
        checks++; if (PC_next !== 32'h704) begin failures++; $display("FAIL mask_inservice_ret got=%h exp=%h", PC_next, 32'h704); end
        checks++; if (irq_active !== 3'b000) begin failures++; $display("FAIL mask_inservice_active got=%b exp=000", irq_active); end
    endtask

    task automatic test_back_to_back();
        PC_old = 32'h800; irq_req = 3'b001;
        step();
        irq_req = 3'b100; irq_done = 1'b1; PC_old = 32'h40;
        step();
        checks++; if (PC_next !== 32'h804) begin failures++; $display("FAIL b2b_pop got=%h exp=%h", PC_next, 32'h804); end
        checks++; if (irq_depth !== 2'd0) begin failures++; $display("FAIL b2b_pop_depth got=%0d exp=0", irq_depth); end
        irq_done = 1'b0; PC_old = 32'h804;
        step();
        checks++; if (PC_next !== 32'hA8) begin failures++; $display("FAIL b2b_take got=%h exp=%h", PC_next, 32'hA8); end
        checks++; if (irq_active !== 3'b100) begin failures++; $display("FAIL b2b_take_active got=%b exp=100", irq_active); end
        irq_req = 3'b000; irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        checks++; if (PC_next !== 32'h808) begin failures++; $display("FAIL b2b_ret got=%h exp=%h", PC_next, 32'h808); end
    endtask

    task automatic test_enable_hold();
        PC_old = 32'h900; irq_req = 3'b001;
        step();
        enable = 1'b0; irq_req = 3'b100; irq_done = 1'b1; PC_old = 32'h1234;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (PC_next !== 32'h38) begin failures++; $display("FAIL hold_pc cyc=%0d got=%h exp=%h", k, PC_next, 32'h38); end
            checks++; if (irq_depth !== 2'd1) begin failures++; $display("FAIL hold_depth cyc=%0d got=%0d exp=1", k, irq_depth); end
            checks++; if (irq_active !== 3'b001) begin failures++; $display("FAIL hold_active cyc=%0d got=%b exp=001", k, irq_active); end
            checks++; if (irq_err !== 1'b1) begin failures++; $display("FAIL hold_err cyc=%0d got=%b exp=1", k, irq_err); end
        end
        enable = 1'b1; irq_req = 3'b000;
        step();
        irq_done = 1'b0;
        checks++; if (PC_next !== 32'h904) begin failures++; $display("FAIL hold_ret got=%h exp=%h", PC_next, 32'h904); end
    endtask

    task automatic test_clr_mid();
        PC_old = 32'hA00; irq_req = 3'b001;
        step();
        irq_req = 3'b100;
        step();
        checks++; if (irq_depth !== 2'd2) begin failures++; $display("FAIL clr_pre_depth got=%0d exp=2", irq_depth); end
        irq_req = 3'b000; clr = 1'b1;
        step();
        clr = 1'b0;
        checks++; if (PC_next !== 32'h0) begin failures++; $display("FAIL clr_pc got=%h exp=%h", PC_next, 32'h0); end
        checks++; if (irq_depth !== 2'd0) begin failures++; $display("FAIL clr_depth got=%0d exp=0", irq_depth); end
        checks++; if (irq_active !== 3'b000) begin failures++; $display("FAIL clr_active got=%b exp=000", irq_active); end
        checks++; if (irq_err !== 1'b0) begin failures++; $display("FAIL clr_err got=%b exp=0", irq_err); end
        PC_old = 32'hB00; irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        checks++; if (PC_next !== 32'hB04) begin failures++; $display("FAIL clr_user_pc got=%h exp=%h", PC_next, 32'hB04); end
        checks++; if (irq_err !== 1'b1) begin failures++; $display("FAIL clr_user_err got=%b exp=1", irq_err); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_single_irq();
        test_nesting();
        test_priority();
        test_error_mask();
        test_back_to_back();
        test_enable_hold();
        test_clr_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
